// File: rtl/scan_xfer_sched.sv
// Round-robin scheduler that hands a shared output channel to one of two scanners
// and streams DEPTH beats from the granted scanner with ready/valid backpressure.
module scan_xfer_sched #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       out_ready,
    output logic [1:0] grant,
    output logic [1:0] xfer_start,
    output logic [1:0] read_inc,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy,
    output logic [7:0] xfer_count0,
    output logic [7:0] xfer_count1
);

    localparam logic [7:0] LastBeat = 8'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRead,
        StAdv,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] beat_q, beat_d;
    logic       last_q, last_d;  // index of the scanner that completed most recently
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;
    logic [1:0] winner;
    logic       is_last_beat;

    assign is_last_beat = (beat_q == LastBeat);

    // Contention goes to whichever scanner did not finish last.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_q ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        last_d     = last_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        xfer_start = 2'b00;
        read_inc   = 2'b00;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = 8'h00;

        case (state_q)
            StIdle: begin
                if (en && (req != 2'b00)) begin
                    grant_d = winner;
                    state_d = StStart;
                end
            end
            StStart: begin
                xfer_start = grant_q;
                beat_d     = 8'h00;
                state_d    = StRead;
            end
            StRead: begin
                out_valid = 1'b1;
                out_last  = is_last_beat;
                out_data  = grant_q[1] ? data1 : data0;
                if (out_ready) begin
                    state_d = StAdv;
                end
            end
            StAdv: begin
                read_inc = grant_q;
                beat_d   = beat_q + 8'd1;
                state_d  = is_last_beat ? StDone : StRead;
            end
            StDone: begin
                if (grant_q[0]) begin
                    cnt0_d = cnt0_q + 8'd1;
                end
                if (grant_q[1]) begin
                    cnt1_d = cnt1_q + 8'd1;
                end
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            beat_q  <= 8'h00;
            last_q  <= 1'b1;
            cnt0_q  <= 8'h00;
            cnt1_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != StIdle);
    assign xfer_count0 = cnt0_q;
    assign xfer_count1 = cnt1_q;

endmodule

// File: tb/tb_scan_xfer_sched.sv
// Bench for scan_xfer_sched: transaction-level model of arbitration, beat stream,
// counters and timing, driven with randomized requests, stalls and data.
module tb_scan_xfer_sched;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       out_ready;
    logic [1:0] grant;
    logic [1:0] xfer_start;
    logic [1:0] read_inc;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic [7:0] xfer_count0;
    logic [7:0] xfer_count1;

    int n_checks = 0;
    int n_pass   = 0;

    // Scanner memories and read pointers, advanced on each observed read_inc.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] ptr0;
    logic [7:0] ptr1;
    int         last_m;
    int         cnt_m [2];

    always #5 clk = ~clk;

    scan_xfer_sched #(
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .out_ready  (out_ready),
        .grant      (grant),
        .xfer_start (xfer_start),
        .read_inc   (read_inc),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .xfer_count0(xfer_count0),
        .xfer_count1(xfer_count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_data();
        data0 = mem0[ptr0];
        data1 = mem1[ptr1];
    endtask

    function automatic int pick_winner(input logic [1:0] rq);
        if (rq == 2'b01) return 0;
        if (rq == 2'b10) return 1;
        return (last_m == 0) ? 1 : 0;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_outs"},
              32'({grant, xfer_start, read_inc, out_valid, out_last, out_data, busy}), 32'(0));
        check({tag, "_cnt0"}, 32'(xfer_count0), 32'(0));
        check({tag, "_cnt1"}, 32'(xfer_count1), 32'(0));
    endtask

    // Asserts rst from the current sample point through one edge.
    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        en  = 1'b0;
        @(posedge clk); #1;
        check_quiet("reset");
        rst       = 1'b0;
        last_m    = 1;
        cnt_m[0]  = 0;
        cnt_m[1]  = 0;
    endtask

    task automatic run_xfer(input logic [1:0] rq, input bit keep, input bit drop_en,
                            input bit stall3, input int abort_beat);
        int         w;
        int         busy_cnt;
        int         stalls;
        int         incs;
        int         nst;
        logic [1:0] oh;
        w         = pick_winner(rq);
        oh        = (w == 0) ? 2'b01 : 2'b10;
        req       = rq;
        en        = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("start_grant", 32'(grant), 32'(oh));
        check("start_pulse", 32'(xfer_start), 32'(oh));
        check("start_quiet", 32'({out_valid, read_inc, out_data}), 32'(0));
        busy_cnt = int'(busy);
        stalls   = 0;
        incs     = 0;
        if (!keep) req = 2'($urandom_range(0, 3));
        if (drop_en) en = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (stall3 && k == 3) nst = 5;
            else nst = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            for (int s = 0; s <= nst; s++) begin
                @(posedge clk); #1;
                busy_cnt += int'(busy);
                if (read_inc != 2'b00) incs++;
                check("read_valid", 32'(out_valid), 32'(1));
                check("read_data", 32'(out_data), 32'((w == 0) ? mem0[ptr0] : mem1[ptr1]));
                check("read_last", 32'(out_last), 32'(k == int'(DEPTH) - 1));
                check("read_pulses", 32'({xfer_start, read_inc}), 32'(0));
                check("read_grant", 32'(grant), 32'(oh));
                if (k == abort_beat) begin
                    out_ready = 1'b1;
                    do_reset();
                    return;
                end
                // The idle scanner's data changes freely; it must never reach out_data.
                if (w == 0) mem1[ptr1] = 8'($urandom);
                else mem0[ptr0] = 8'($urandom);
                drive_data();
                if (s < nst) stalls++;
                out_ready = (s == nst);
            end
            @(posedge clk); #1;
            busy_cnt += int'(busy);
            if (read_inc != 2'b00) incs++;
            check("adv_inc", 32'(read_inc), 32'(oh));
            check("adv_quiet", 32'({out_valid, out_last, out_data, xfer_start}), 32'(0));
            out_ready = 1'($urandom);
            if (w == 0) ptr0 = ptr0 + 8'd1;
            else ptr1 = ptr1 + 8'd1;
            drive_data();
        end
        @(posedge clk); #1;
        busy_cnt += int'(busy);
        check("done_grant", 32'(grant), 32'(oh));
        check("done_quiet", 32'({out_valid, out_last, xfer_start, read_inc}), 32'(0));
        req = keep ? rq : 2'b00;
        @(posedge clk); #1;
        cnt_m[w] = (cnt_m[w] + 1) % 256;
        last_m   = w;
        check("idle_grant", 32'(grant), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("count0", 32'(xfer_count0), 32'(cnt_m[0]));
        check("count1", 32'(xfer_count1), 32'(cnt_m[1]));
        check("busy_len", 32'(busy_cnt), 32'(2 * DEPTH + 2 + stalls));
        check("inc_total", 32'(incs), 32'(DEPTH));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'(10 + i);
            mem1[i] = 8'($urandom);
        end
        ptr0      = 8'h00;
        ptr1      = 8'h00;
        out_ready = 1'b0;
        drive_data();
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Single request, no stalls beyond the random ones.
        run_xfer(2'b01, 1'b0, 1'b0, 1'b0, -1);
        check("single_cnt0", 32'(xfer_count0), 32'(1));

        // Contention from reset: 0,1,0 with req held (also no regrant during DONE).
        do_reset();
        for (int t = 0; t < 3; t++) run_xfer(2'b11, 1'b1, 1'b0, 1'b0, -1);
        req = 2'b00;
        check("contend_cnt0", 32'(xfer_count0), 32'(2));
        check("contend_cnt1", 32'(xfer_count1), 32'(1));

        // Five-cycle stall on beat 3.
        run_xfer(2'b01, 1'b0, 1'b0, 1'b1, -1);

        // Gating: en low blocks grants; dropping en mid-transfer still completes it.
        en  = 1'b0;
        req = 2'b10;
        repeat (4) begin
            @(posedge clk); #1;
            check("gated_idle", 32'({grant, busy}), 32'(0));
        end
        run_xfer(2'b10, 1'b0, 1'b1, 1'b0, -1);
        req = 2'b11;
        repeat (3) begin
            @(posedge clk); #1;
            check("gated_after", 32'({grant, busy}), 32'(0));
        end
        req = 2'b00;

        // Randomized mix of requests, holds and stalls.
        repeat (20) begin
            run_xfer(2'($urandom_range(1, 3)), 1'($urandom), 1'b0, 1'b0, -1);
        end
        req = 2'b00;

        // Reset while beat 4 is presented, then contention restarts with scanner 0.
        run_xfer(2'b10, 1'b0, 1'b0, 1'b0, 4);
        run_xfer(2'b11, 1'b0, 1'b0, 1'b0, -1);
        check("post_reset_first", 32'(xfer_count0), 32'(1));

        // 256 transfers on scanner 1 wrap its counter to zero.
        do_reset();
        repeat (256) run_xfer(2'b10, 1'b0, 1'b0, 1'b0, -1);
        check("wrap_cnt1", 32'(xfer_count1), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_xfer_sched.md
SCAN_XFER_SCHED -- requirements
Module: scan_xfer_sched

Interface
REQ-001 The block SHALL have a single parameter: DEPTH, default 8, beats per transfer, legal range 2..255.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL provide the following ports (name, direction, width, meaning):
  clk  in  1  system clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  en  in  1  1 = new grants allowed; 0 = finish current transfer, grant no new one
  req  in  2  per-scanner ready_to_transfer request, bit i = scanner i
  data0  in  8  scanner 0 read data at its current read pointer
  data1  in  8  scanner 1 read data at its current read pointer
  out_ready  in  1  sink accepts beat
  grant  out  2  one-hot owner of channel, 00 when idle
  xfer_start  out  2  one-cycle one-hot start_transfer pulse to granted scanner
  read_inc  out  2  one-cycle one-hot read-pointer advance to granted scanner
  out_data  out  8  beat data
  out_valid  out  1  beat valid
  out_last  out  1  marks final beat (beat index DEPTH-1), only with out_valid
  busy  out  1  1 in any state except IDLE
  xfer_count0  out  8  completed transfers, scanner 0
  xfer_count1  out  8  completed transfers, scanner 1

Function
REQ-004 The block SHALL implement the FSM states IDLE, START, READ, ADV and DONE.
REQ-005 In IDLE with en=1 and req!=00, the block SHALL register the winner into grant and move to START at the next edge.
REQ-006 In IDLE with en=0 or req=00, the block SHALL stay in IDLE with grant=00.
REQ-007 Arbitration SHALL be round-robin:
  - single request wins
  - both requesting -> the scanner NOT granted last wins
  - after reset, priority SHALL go to scanner 0
REQ-008 In START, xfer_start[g] SHALL be 1 for exactly one cycle, the beat counter SHALL be cleared to 0, and the next state SHALL be READ.
REQ-009 In READ, out_valid SHALL be 1 and out_data SHALL equal data of the granted scanner (combinational mux).
REQ-010 In READ, out_last SHALL be 1 iff beat counter = DEPTH-1.
REQ-011 READ SHALL hold while out_ready=0, with out_data tracking the granted input.
REQ-012 On a READ cycle with out_ready=1, the beat SHALL be accepted and the next state SHALL be ADV.
REQ-013 In ADV, read_inc[g] SHALL be 1 for one cycle and the beat counter SHALL increment.
REQ-014 From ADV, the next state SHALL be DONE if the accepted beat was the last, else READ.
REQ-015 In DONE (one cycle), the block SHALL:
  - increment xfer_count of the granted scanner (8-bit, 255 wraps to 0)
  - record the last-granted scanner
  - return to IDLE with grant=00
REQ-016 Outside their defined states, out_valid, out_last, xfer_start and read_inc SHALL be 0, and out_data SHALL be 0.
REQ-017 Deassertion of req or en during START/READ/ADV/DONE SHALL NOT abort the transfer.
REQ-018 A request asserted during DONE SHALL be evaluated in the following IDLE cycle (no same-cycle regrant).
REQ-019 Timing with out_ready held 1 SHALL be:
  - xfer_start high 1 cycle after grant registration
  - first out_valid 1 cycle later
  - one beat per 2 cycles
  - busy high for exactly 2*DEPTH+2 cycles per transfer
REQ-020 At most one bit of grant, xfer_start and read_inc SHALL be set in any cycle.

Reset
REQ-021 When rst=1 at an edge, the block SHALL:
  - go to IDLE
  - set grant=00, xfer_start=00, read_inc=00, out_valid=0, out_last=0, out_data=0, busy=0
  - set xfer_count0=xfer_count1=0, beat counter=0
  - give round-robin priority to scanner 0
REQ-022 Reset during any active state SHALL abandon the transfer, issue no further pulses, and leave counts unchanged-to-zero.

Verification
REQ-023 Single request: DEPTH=8, req=01, en=1, out_ready=1, data0 increments per read_inc from 10 -> one xfer_start[0] pulse, beats 10..17, out_last on 17, 8 read_inc[0] pulses, xfer_count0=1, busy 18 cycles.
REQ-024 Contention: req=11 held for 3 transfers after reset -> grant order 0,1,0; xfer_count0=2, xfer_count1=1.
REQ-025 Backpressure: out_ready=0 for 5 cycles on beat 3 -> out_valid held, no read_inc during stall, beat data unchanged, total beats still 8.
REQ-026 Gating: en=0 with req=10 -> grant stays 00, busy=0; en dropped mid-transfer -> transfer completes, no new grant.
REQ-027 Reset mid-READ on beat 4 -> next cycle all outputs 0, counts 0; then req=11 -> scanner 0 granted first.
REQ-028 Wrap: 256 transfers on scanner 1 -> xfer_count1 returns to 0.
